// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder: opcode masks,
// DDRAM geometry, line address limits, the responder state enum and the
// address-counter helpers used by both the write path and the peek port.
package lcd_pkg;

  // Instruction opcode masks; the highest set bit selects the instruction.
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_SHIFT = 8'h10;
  localparam logic [7:0] OP_FUNC  = 8'h20;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_DDRAM = 8'h80;

  localparam int DDRAM_DEPTH = 80;

  // Line base/end addresses as seen on the address counter.
  localparam logic [6:0] LINE1_BASE   = 7'h00;
  localparam logic [6:0] LINE1_END    = 7'h27;
  localparam logic [6:0] LINE2_BASE   = 7'h40;
  localparam logic [6:0] LINE2_END    = 7'h67;
  localparam logic [6:0] ONE_LINE_END = 7'h4F;

  localparam logic [7:0] SPACE_CODE = 8'h20;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_IDLE = 2'd1,
    ST_EXEC = 2'd2
  } resp_state_e;

  // True when the address lies inside the active map for the line mode.
  function automatic logic ddram_valid(input logic [6:0] a, input logic two);
    if (two) return (a <= LINE1_END) || ((a >= LINE2_BASE) && (a <= LINE2_END));
    return a <= ONE_LINE_END;
  endfunction

  // Address counter value to physical DDRAM index; stray addresses land on 0.
  function automatic logic [6:0] ddram_index(input logic [6:0] a, input logic two);
    if (!ddram_valid(a, two)) return 7'd0;
    if (two && (a >= LINE2_BASE)) return a - 7'd24;
    return a;
  endfunction

  // One address-counter step with the line wrap rules of the current mode.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc,
                                         input logic two);
    logic [6:0] n;
    if (two) begin
      if (inc) n = (a == LINE1_END) ? LINE2_BASE :
                   (a == LINE2_END) ? LINE1_BASE : a + 7'd1;
      else     n = (a == LINE2_BASE) ? LINE1_END :
                   (a == LINE1_BASE) ? LINE2_END : a - 7'd1;
    end else begin
      if (inc) n = (a == ONE_LINE_END) ? LINE1_BASE : a + 7'd1;
      else     n = (a == LINE1_BASE) ? ONE_LINE_END : a - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Two-flop synchronizer for a bundle of asynchronous bus lines. Bit 0 is the
// strobe line: a third flop on it provides a one-cycle falling-edge pulse.
// clr_i holds every flop at its reset value (panel power off).
module lcd_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         fall_o
);

  logic [W-1:0] s1_q, s2_q;
  logic         s3_q;

  // Synchronizer chain plus the extra edge-detect stage on the strobe bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= 1'b0;
    end else if (clr_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q[0];
    end
  end

  assign q_o    = s2_q;
  assign fall_o = s3_q & ~s2_q[0];

endmodule

// File: rtl/lcd_bus_responder.sv
// LCD-side responder for the 8-bit HD44780-style parallel bus. Decodes host
// writes, keeps an 80-byte DDRAM, address counter and display state, and
// answers busy/address and data reads on data_lcd.
// Optional build macro LCD_RESP_STRICT_EN: writes arriving while busy are
// dropped and latch protocol_err; without it they execute and restart busy.
// CLEAR_CYCLES must be at least 81 (the 80-cycle fill is part of it).
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on_lcd,
  input  logic       en_lcd,
  input  logic       rs_lcd,
  input  logic       rw_lcd,
  inout  wire  [7:0] data_lcd,
  output logic       cmd_strobe,
  output logic       cmd_rs,
  output logic [7:0] cmd_data,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       two_line,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       protocol_err
);

  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  // Remaining countdown once the 80-cycle clear fill is done.
  localparam logic [CNT_W-1:0] CLEAR_TAIL = CNT_W'(CLEAR_CYCLES - DDRAM_DEPTH - 1);
  localparam logic [6:0]       FILL_LAST  = 7'(DDRAM_DEPTH - 1);

  // Synchronized bus: {data, rw, rs, en}
  logic [10:0] bus_raw, bus_s;
  logic        en_s, rs_s, rw_s, en_fall;
  logic [7:0]  data_s;

  assign bus_raw = {data_lcd, rw_lcd, rs_lcd, en_lcd};

  lcd_sync_edge #(.W(11)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (~on_lcd),
    .d_i    (bus_raw),
    .q_o    (bus_s),
    .fall_o (en_fall)
  );

  assign en_s   = bus_s[0];
  assign rs_s   = bus_s[1];
  assign rw_s   = bus_s[2];
  assign data_s = bus_s[10:3];

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       fill_q, fill_d;
  logic             clr_pend_q, clr_pend_d;
  logic [6:0]       ac_q, ac_d;
  logic             inc_q, inc_d, disp_q, disp_d, cur_q, cur_d;
  logic             blink_q, blink_d, two_q, two_d;
  logic             strobe_q, strobe_d, cmd_rs_q, cmd_rs_d, err_q, err_d;
  logic [7:0]       cmd_data_q, cmd_data_d;

  logic [7:0] mem_q [DDRAM_DEPTH];
  logic       mem_we;
  logic [6:0] mem_widx;
  logic [7:0] mem_wdata;

  logic wr_req, wr_acc, wr_rej;

  assign wr_req = en_fall & ~rw_s;

`ifdef LCD_RESP_STRICT_EN
  // Busy as seen by a new write: a countdown expiring this cycle counts as free.
  logic busy_eff;
  assign busy_eff = (state_q == ST_FILL) | ((state_q == ST_EXEC) & (cnt_q != '0));
  assign wr_acc   = wr_req & ~busy_eff;
  assign wr_rej   = wr_req &  busy_eff;
`else
  assign wr_acc   = wr_req;
  assign wr_rej   = 1'b0;
`endif

  // Next-state: FSM sequencing, instruction/data decode and DDRAM write port.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    clr_pend_d = clr_pend_q;
    ac_d       = ac_q;
    inc_d      = inc_q;
    disp_d     = disp_q;
    cur_d      = cur_q;
    blink_d    = blink_q;
    two_d      = two_q;
    strobe_d   = 1'b0;
    cmd_rs_d   = cmd_rs_q;
    cmd_data_d = cmd_data_q;
    err_d      = err_q | wr_rej;
    mem_we     = 1'b0;
    mem_widx   = fill_q;
    mem_wdata  = SPACE_CODE;

    case (state_q)
      ST_FILL: begin
        mem_we = 1'b1;
        if (fill_q == FILL_LAST) begin
          fill_d = 7'd0;
          if (clr_pend_q) begin
            clr_pend_d = 1'b0;
            ac_d       = 7'd0;
            inc_d      = 1'b1;
            cnt_d      = CLEAR_TAIL;
            state_d    = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    // Data reads advance the counter when the host releases the strobe.
    if (en_fall && rw_s && rs_s) ac_d = ac_step(ac_q, inc_q, two_q);

    if (wr_acc) begin
      strobe_d   = 1'b1;
      cmd_rs_d   = rs_s;
      cmd_data_d = data_s;
      state_d    = ST_EXEC;
      cnt_d      = BUSY_LOAD;
      fill_d     = 7'd0;
      clr_pend_d = 1'b0;
      if (rs_s) begin
        mem_we    = 1'b1;
        mem_widx  = ddram_index(ac_q, two_q);
        mem_wdata = data_s;
        ac_d      = ac_step(ac_q, inc_q, two_q);
      end else if (|(data_s & OP_DDRAM)) begin
        ac_d = ddram_valid(data_s[6:0], two_q) ? data_s[6:0] : 7'd0;
      end else if (|(data_s & OP_CGRAM)) begin
        // CGRAM is not modelled; only the busy time applies.
      end else if (|(data_s & OP_FUNC)) begin
        two_d = data_s[3];
      end else if (|(data_s & OP_SHIFT)) begin
        if (!data_s[3]) ac_d = ac_step(ac_q, data_s[2], two_q);
      end else if (|(data_s & OP_DISP)) begin
        disp_d  = data_s[2];
        cur_d   = data_s[1];
        blink_d = data_s[0];
      end else if (|(data_s & OP_ENTRY)) begin
        inc_d = data_s[1];
      end else if (|(data_s & OP_HOME)) begin
        ac_d  = 7'd0;
        cnt_d = CLEAR_LOAD;
      end else if (|(data_s & OP_CLEAR)) begin
        state_d    = ST_FILL;
        clr_pend_d = 1'b1;
      end
    end

    // Panel off: everything sits at its reset value.
    if (!on_lcd) begin
      state_d    = ST_FILL;
      cnt_d      = '0;
      fill_d     = 7'd0;
      clr_pend_d = 1'b0;
      ac_d       = 7'd0;
      inc_d      = 1'b1;
      disp_d     = 1'b0;
      cur_d      = 1'b0;
      blink_d    = 1'b0;
      two_d      = 1'b0;
      strobe_d   = 1'b0;
      cmd_rs_d   = 1'b0;
      cmd_data_d = 8'h00;
      err_d      = 1'b0;
      mem_we     = 1'b0;
    end
  end

  // Control and state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      fill_q     <= 7'd0;
      clr_pend_q <= 1'b0;
      ac_q       <= 7'd0;
      inc_q      <= 1'b1;
      disp_q     <= 1'b0;
      cur_q      <= 1'b0;
      blink_q    <= 1'b0;
      two_q      <= 1'b0;
      strobe_q   <= 1'b0;
      cmd_rs_q   <= 1'b0;
      cmd_data_q <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      clr_pend_q <= clr_pend_d;
      ac_q       <= ac_d;
      inc_q      <= inc_d;
      disp_q     <= disp_d;
      cur_q      <= cur_d;
      blink_q    <= blink_d;
      two_q      <= two_d;
      strobe_q   <= strobe_d;
      cmd_rs_q   <= cmd_rs_d;
      cmd_data_q <= cmd_data_d;
      err_q      <= err_d;
    end
  end

  // DDRAM storage; contents are rebuilt by the fill after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  // Read path: bus is driven only while the synchronized strobe is high on a read.
  logic       rd_drive;
  logic [7:0] rd_data;

  assign rd_drive = en_s & rw_s;
  assign rd_data  = rs_s ? mem_q[ddram_index(ac_q, two_q)] : {busy, ac_q};
  assign data_lcd = rd_drive ? rd_data : 8'bz;

  assign dbg_data     = mem_q[ddram_index(dbg_addr, two_q)];
  assign busy         = (state_q != ST_IDLE);
  assign ac           = ac_q;
  assign inc_mode     = inc_q;
  assign disp_on      = disp_q;
  assign cursor_on    = cur_q;
  assign blink_on     = blink_q;
  assign two_line     = two_q;
  assign cmd_strobe   = strobe_q;
  assign cmd_rs       = cmd_rs_q;
  assign cmd_data     = cmd_data_q;
  assign protocol_err = err_q;

endmodule
